cable_sequencer: RTL and testbench
==================================

Name: cable_sequencer

Overview:
- Game-level controller for the swinging cable/hook datapath.
- Sequences the cable through swing, launch, extend, retract and deliver phases.
- Latches the object grabbed on collision and throttles reel-in speed by object weight.
- Issues object-removal and score pulses to the object bank and score counter. Sits between the key debouncer, the collision detector and the cable motion block.

Parameters:
- NUM_OBJ_W, 3, width of object ID (up to 8 objects)
- MAX_EXTEND_FRAMES, 120, frames of extension before forced retract
- DELIVER_FRAMES, 15, frames spent in DELIVER before swing resumes
- SCORE_W, 12, width of scoreValue

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- gameEnable  in  1  level; low forces IDLE
- launchKey  in  1  debounced key level
- cableHome  in  1  cable is at its swing position
- hitObject  in  1  cable tip overlaps an object (level)
- hitObjectId  in  NUM_OBJ_W  ID of overlapped object
- hitObjectWeight  in  2  weight class 0..3 of overlapped object
- hitEdge  in  1  cable tip reached screen edge
- launch_Cable  out  1  one-cycle launch pulse to motion block
- retract  out  1  level: reverse/retract cable
- moveEnable  out  1  one-cycle strobe: motion block may integrate this frame
- grabbedValid  out  1  an object is attached
- grabbedId  out  NUM_OBJ_W  attached object ID
- removeObject  out  1  one-cycle pulse: delete grabbedId from bank
- scoreAdd  out  1  one-cycle pulse: add scoreValue
- scoreValue  out  SCORE_W  points for delivered object
- stateOut  out  3  current FSM state encoding

Behaviour:
- Reset:
  - state=IDLE; all outputs 0.
  - Frame/divider counters 0; launchKey edge-detect register 0.
- States: IDLE, SWING, LAUNCH, EXTEND, RETRACT, DELIVER.
- IDLE: leaves to SWING on the cycle after gameEnable=1.
- Any state with gameEnable=0:
  - next cycle goes to IDLE.
  - Clears grabbedValid and retract.
  - No removeObject, no scoreAdd.
- SWING:
  - moveEnable=startOfFrame.
  - Rising edge of launchKey while cableHome=1 -> LAUNCH.
  - A key held through entry into SWING does not launch; a new rising edge is required.
- LAUNCH: exactly one cycle; launch_Cable=1; extend frame counter cleared; -> EXTEND.
- EXTEND:
  - moveEnable=startOfFrame; counter increments per startOfFrame.
  - hitObject=1 -> latch grabbedId=hitObjectId, weight=hitObjectWeight, grabbedValid=1; -> RETRACT.
  - Else hitEdge=1, or counter reaches MAX_EXTEND_FRAMES -> RETRACT with weight=0, grabbedValid=0.
  - hitObject and hitEdge in the same cycle: the object wins.
- RETRACT:
  - retract=1.
  - Divider counts startOfFrame modulo (weight+1).
  - moveEnable=startOfFrame when divider==0, so weight 3 moves every 4th frame.
  - Divider cleared on entry.
  - hitObject/hitEdge ignored.
  - cableHome=1 -> DELIVER if grabbedValid, else SWING; retract drops on exit.
- DELIVER:
  - First cycle: removeObject=1, scoreAdd=1, scoreValue from table by weight: 0->50, 1->100, 2->250, 3->500.
  - scoreValue holds while in DELIVER.
  - Counts DELIVER_FRAMES startOfFrame pulses, then -> SWING, clears grabbedValid.
  - moveEnable=0 throughout.
- Pulses (launch_Cable, removeObject, scoreAdd) are registered, exactly one cycle, and never asserted outside their state.
- stateOut encodings: IDLE=0, SWING=1, LAUNCH=2, EXTEND=3, RETRACT=4, DELIVER=5.
- Counter widths: sized by $clog2 of their parameter; no wrap possible before the terminal count.

Decomposition:
- Shared package cable_pkg:
  - state enum.
  - weight typedef (2-bit).
  - score table constant array.
  - stateOut encodings.
- One sub-module: frame_divider. Counts startOfFrame modulo (div+1), clears on load, emits the strobe. Used for RETRACT throttling; instantiated generically.

Test Plan:
- Reset mid-EXTEND: assert resetN=0 -> stateOut=0 and all outputs 0 asynchronously; after release with gameEnable=1 -> SWING next cycle.
- Launch edge: launchKey rises with cableHome=1 in SWING -> launch_Cable high exactly one cycle, stateOut 2 then 3. Key held through a later return to SWING -> no relaunch.
- Grab and reel: hitObject=1, id=5, weight=3 in EXTEND -> grabbedId=5, retract=1; moveEnable on every 4th startOfFrame.
  - On cableHome -> removeObject and scoreAdd pulse once, scoreValue=500.
  - SWING after 15 frames.
- Empty return:
  - hitEdge=1 -> retract with moveEnable every frame; cableHome -> SWING with no scoreAdd.
  - Separately, no hits for 120 frames -> forced RETRACT.
- Simultaneous hitObject=1 (id=2, weight=1) and hitEdge=1 -> grabbedValid=1, moveEnable every 2nd frame, scoreValue=100.
- gameEnable dropped during RETRACT with an object attached -> IDLE next cycle, grabbedValid=0, no removeObject/scoreAdd.

Source files
------------

// File: rtl/cable_pkg.sv
// Shared types and constants for the cable/hook game sequencer: state encoding,
// object weight class and the delivery score table.
package cable_pkg;

  localparam int STATE_W = 3;

  // Values double as the stateOut encoding seen by the rest of the game.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SWING   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_EXTEND  = 3'd3,
    ST_RETRACT = 3'd4,
    ST_DELIVER = 3'd5
  } state_e;

  typedef logic [1:0] weight_t;

  localparam int unsigned SCORE_TABLE [4] = '{50, 100, 250, 500};

  function automatic int unsigned score_for(weight_t w);
    return SCORE_TABLE[w];
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts tick_i modulo (div_i+1) and strobes on the tick that finds the count at
// zero, so the first tick after a load always strobes.
module frame_divider #(
  parameter int DIV_W = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load_i,
  input  logic             tick_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             strobe_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = (cnt_q == div_i) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe_o = tick_i && (cnt_q == '0);

endmodule

// File: rtl/cable_sequencer.sv
// Game-level controller for the swinging cable: swing, launch, extend, retract
// and deliver phases, with weight-throttled reel-in and score/removal pulses.
module cable_sequencer
  import cable_pkg::*;
#(
  parameter int NUM_OBJ_W         = 3,
  parameter int MAX_EXTEND_FRAMES = 120,
  parameter int DELIVER_FRAMES    = 15,
  parameter int SCORE_W           = 12
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 gameEnable,
  input  logic                 launchKey,
  input  logic                 cableHome,
  input  logic                 hitObject,
  input  logic [NUM_OBJ_W-1:0] hitObjectId,
  input  logic [1:0]           hitObjectWeight,
  input  logic                 hitEdge,
  output logic                 launch_Cable,
  output logic                 retract,
  output logic                 moveEnable,
  output logic                 grabbedValid,
  output logic [NUM_OBJ_W-1:0] grabbedId,
  output logic                 removeObject,
  output logic                 scoreAdd,
  output logic [SCORE_W-1:0]   scoreValue,
  output logic [2:0]           stateOut
);

  localparam int EXT_W = $clog2(MAX_EXTEND_FRAMES + 1);
  localparam int DLV_W = $clog2(DELIVER_FRAMES + 1);
  localparam logic [EXT_W-1:0] EXT_LAST = EXT_W'(MAX_EXTEND_FRAMES);
  localparam logic [DLV_W-1:0] DLV_LAST = DLV_W'(DELIVER_FRAMES - 1);

  state_e               state_q, state_d;
  logic                 key_q;
  logic [EXT_W-1:0]     ext_cnt_q, ext_cnt_d;
  logic [DLV_W-1:0]     dlv_cnt_q, dlv_cnt_d;
  weight_t              weight_q, weight_d;
  logic                 valid_q, valid_d;
  logic [NUM_OBJ_W-1:0] id_q, id_d;
  logic                 launch_q, launch_d;
  logic                 remove_q, remove_d;
  logic                 score_add_q, score_add_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 key_rise;
  logic                 div_load;
  logic                 div_tick;
  logic                 div_strobe;

  // key_q samples in every state, so a key held across entry to SWING shows no edge.
  assign key_rise = launchKey && !key_q;

  always_comb begin
    state_d   = state_q;
    ext_cnt_d = ext_cnt_q;
    dlv_cnt_d = dlv_cnt_q;
    weight_d  = weight_q;
    valid_d   = valid_q;
    id_d      = id_q;
    if (!gameEnable) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      id_d     = '0;
      weight_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SWING;
        ST_SWING: begin
          if (key_rise && cableHome) state_d = ST_LAUNCH;
        end
        ST_LAUNCH: begin
          ext_cnt_d = '0;
          state_d   = ST_EXTEND;
        end
        ST_EXTEND: begin
          if (hitObject) begin
            id_d     = hitObjectId;
            weight_d = hitObjectWeight;
            valid_d  = 1'b1;
            state_d  = ST_RETRACT;
          end else if (hitEdge || ext_cnt_q == EXT_LAST) begin
            weight_d = '0;
            valid_d  = 1'b0;
            state_d  = ST_RETRACT;
          end else if (startOfFrame) begin
            ext_cnt_d = ext_cnt_q + EXT_W'(1);
          end
        end
        ST_RETRACT: begin
          if (cableHome) begin
            dlv_cnt_d = '0;
            state_d   = valid_q ? ST_DELIVER : ST_SWING;
          end
        end
        ST_DELIVER: begin
          if (startOfFrame) begin
            if (dlv_cnt_q == DLV_LAST) begin
              valid_d = 1'b0;
              id_d    = '0;
              state_d = ST_SWING;
            end else begin
              dlv_cnt_d = dlv_cnt_q + DLV_W'(1);
            end
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Pulses are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    launch_d    = (state_d == ST_LAUNCH);
    remove_d    = (state_d == ST_DELIVER) && (state_q != ST_DELIVER);
    score_add_d = remove_d;
    score_d     = (state_d == ST_DELIVER) ? SCORE_W'(score_for(weight_d)) : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      key_q       <= 1'b0;
      ext_cnt_q   <= '0;
      dlv_cnt_q   <= '0;
      weight_q    <= '0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      launch_q    <= 1'b0;
      remove_q    <= 1'b0;
      score_add_q <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= launchKey;
      ext_cnt_q   <= ext_cnt_d;
      dlv_cnt_q   <= dlv_cnt_d;
      weight_q    <= weight_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      launch_q    <= launch_d;
      remove_q    <= remove_d;
      score_add_q <= score_add_d;
      score_q     <= score_d;
    end
  end

  assign div_load = (state_d == ST_RETRACT) && (state_q != ST_RETRACT);
  assign div_tick = startOfFrame && (state_q == ST_RETRACT);

  frame_divider #(
    .DIV_W ($bits(weight_t))
  ) u_reel_div (
    .clk      (clk),
    .resetN   (resetN),
    .load_i   (div_load),
    .tick_i   (div_tick),
    .div_i    (weight_q),
    .strobe_o (div_strobe)
  );

  assign moveEnable   = startOfFrame && ((state_q == ST_SWING) || (state_q == ST_EXTEND) ||
                                         ((state_q == ST_RETRACT) && div_strobe));
  assign retract      = (state_q == ST_RETRACT);
  assign launch_Cable = launch_q;
  assign removeObject = remove_q;
  assign scoreAdd     = score_add_q;
  assign scoreValue   = score_q;
  assign grabbedValid = valid_q;
  assign grabbedId    = id_q;
  assign stateOut     = state_q;

endmodule

// File: tb/tb_cable_sequencer.sv
// Directed bench for cable_sequencer: launch, grab/reel/deliver, empty returns,
// forced retract, hit priority, gameEnable drop and asynchronous reset.
module tb_cable_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, gameEnable, launchKey, cableHome;
  logic       hitObject, hitEdge;
  logic [2:0] hitObjectId;
  logic [1:0] hitObjectWeight;
  logic       launch_Cable, retract, moveEnable, grabbedValid;
  logic [2:0] grabbedId;
  logic       removeObject, scoreAdd;
  logic [11:0] scoreValue;
  logic [2:0] stateOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cable_sequencer dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .gameEnable      (gameEnable),
    .launchKey       (launchKey),
    .cableHome       (cableHome),
    .hitObject       (hitObject),
    .hitObjectId     (hitObjectId),
    .hitObjectWeight (hitObjectWeight),
    .hitEdge         (hitEdge),
    .launch_Cable    (launch_Cable),
    .retract         (retract),
    .moveEnable      (moveEnable),
    .grabbedValid    (grabbedValid),
    .grabbedId       (grabbedId),
    .removeObject    (removeObject),
    .scoreAdd        (scoreAdd),
    .scoreValue      (scoreValue),
    .stateOut        (stateOut)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: startOfFrame high for one clock, then one idle clock.
  task automatic frame(output logic me);
    startOfFrame = 1'b1;
    #1;
    me = moveEnable;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    step();
  endtask

  // From SWING with the cable home: fresh key edge, through LAUNCH into EXTEND.
  task automatic do_launch();
    cableHome = 1'b1;
    launchKey = 1'b0;
    step();
    launchKey = 1'b1;
    step();
    step();
    cableHome = 1'b0;
  endtask

  initial begin
    logic       me;
    logic [7:0] mask;
    int         moves;

    resetN = 1'b0; gameEnable = 1'b0; startOfFrame = 1'b0; launchKey = 1'b0;
    cableHome = 1'b0; hitObject = 1'b0; hitEdge = 1'b0;
    hitObjectId = '0; hitObjectWeight = '0;
    repeat (3) step();
    check("reset_state", stateOut, 0);
    check("reset_outputs", {launch_Cable, retract, grabbedValid, removeObject, scoreAdd}, 0);
    check("reset_score", scoreValue, 0);
    resetN = 1'b1;
    gameEnable = 1'b1;
    step();
    check("idle_to_swing", stateOut, 1);

    // Launch edge: pulse for exactly one cycle.
    cableHome = 1'b1;
    launchKey = 1'b1;
    step();
    check("launch_state", stateOut, 2);
    check("launch_pulse", launch_Cable, 1);
    step();
    check("extend_state", stateOut, 3);
    check("launch_pulse_gone", launch_Cable, 0);
    cableHome = 1'b0;
    frame(me);
    check("extend_move", me, 1);

    // Grab id 5 weight 3, reel in every 4th frame.
    hitObject = 1'b1; hitObjectId = 3'd5; hitObjectWeight = 2'd3;
    step();
    hitObject = 1'b0; hitObjectId = '0; hitObjectWeight = '0;
    check("grab_state", stateOut, 4);
    check("grab_valid_id", {grabbedValid, grabbedId}, {1'b1, 3'd5});
    check("grab_retract", retract, 1);
    for (int i = 0; i < 8; i++) begin
      frame(me);
      mask[i] = me;
    end
    check("w3_move_mask", mask, 8'b0001_0001);
    cableHome = 1'b1;
    step();
    check("deliver_state", stateOut, 5);
    check("deliver_pulses", {removeObject, scoreAdd, retract}, 3'b110);
    check("deliver_score500", scoreValue, 500);
    step();
    check("deliver_pulses_once", {removeObject, scoreAdd}, 0);
    moves = 0;
    for (int i = 0; i < 14; i++) begin
      frame(me);
      moves += int'(me);
    end
    check("deliver_after14", stateOut, 5);
    check("deliver_score_hold", scoreValue, 500);
    frame(me);
    moves += int'(me);
    check("deliver_no_move", moves, 0);
    check("deliver_to_swing", stateOut, 1);
    check("deliver_clears_valid", grabbedValid, 0);

    // Key still held since launch: no relaunch.
    repeat (3) step();
    check("held_key_no_launch", {stateOut, launch_Cable}, {3'd1, 1'b0});

    // Empty return via edge: weight 0 moves every frame, no scoring.
    do_launch();
    hitEdge = 1'b1;
    step();
    hitEdge = 1'b0;
    check("edge_retract", {stateOut, grabbedValid}, {3'd4, 1'b0});
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      frame(me);
      mask[i] = me;
    end
    check("w0_move_mask", mask, 8'b0000_1111);
    cableHome = 1'b1;
    step();
    check("empty_home_swing", {stateOut, scoreAdd, removeObject}, {3'd1, 2'b00});

    // Forced retract after 120 frames without hits.
    do_launch();
    for (int i = 0; i < 119; i++) frame(me);
    check("extend_after119", stateOut, 3);
    frame(me);
    check("forced_retract", {stateOut, grabbedValid}, {3'd4, 1'b0});
    cableHome = 1'b1;
    step();
    check("forced_home_swing", stateOut, 1);

    // Object and edge together: object wins.
    do_launch();
    hitObject = 1'b1; hitEdge = 1'b1; hitObjectId = 3'd2; hitObjectWeight = 2'd1;
    step();
    hitObject = 1'b0; hitEdge = 1'b0; hitObjectId = '0; hitObjectWeight = '0;
    check("both_hit_grab", {stateOut, grabbedValid, grabbedId}, {3'd4, 1'b1, 3'd2});
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      frame(me);
      mask[i] = me;
    end
    check("w1_move_mask", mask, 8'b0000_0101);
    cableHome = 1'b1;
    step();
    check("deliver_score100", {scoreAdd, scoreValue}, {1'b1, 12'd100});
    for (int i = 0; i < 15; i++) frame(me);
    check("w1_back_to_swing", stateOut, 1);

    // gameEnable dropped while reeling an object.
    do_launch();
    hitObject = 1'b1; hitObjectId = 3'd6; hitObjectWeight = 2'd2;
    step();
    hitObject = 1'b0;
    check("drop_pre_valid", {stateOut, grabbedValid}, {3'd4, 1'b1});
    gameEnable = 1'b0;
    cableHome = 1'b1;
    step();
    check("drop_to_idle", {stateOut, grabbedValid, retract}, {3'd0, 2'b00});
    check("drop_no_pulses", {removeObject, scoreAdd}, 0);
    step();
    check("drop_no_pulses_later", {removeObject, scoreAdd, stateOut}, 0);
    gameEnable = 1'b1;
    step();
    check("reenable_swing", stateOut, 1);

    // Asynchronous reset in the middle of EXTEND.
    do_launch();
    check("pre_reset_extend", stateOut, 3);
    #1;
    resetN = 1'b0;
    startOfFrame = 1'b1;
    #1;
    check("async_reset_state", stateOut, 0);
    check("async_reset_outputs", {launch_Cable, retract, moveEnable, grabbedValid, removeObject, scoreAdd}, 0);
    startOfFrame = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    check("post_reset_swing", stateOut, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
